// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and FSM state type for the ALU sequencer
// Contents:
//   DATA_W      ALU slice width (request/response data are 2*DATA_W)
//   SEL_W       ALU select width
//   ALU_SEL_MAX highest legal select; anything above is rejected with rsp_err
//   state_t     sequencer FSM states IDLE, LO, HI, RSP
package alu_pkg;

   localparam int DATA_W = 16;
   localparam int SEL_W  = 5;
   localparam logic [SEL_W-1:0] ALU_SEL_MAX = 5'd19;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      RSP  = 2'd3
   } state_t;

endpackage

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - valid/ready sequencer driving a 16-bit combinational ALU, 1 or 2 passes
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_sel, req_a, req_b    operation select and 2*DATA_W operands
//   req_cin, req_wide        initial carry-in, 1 = two-pass 32-bit operation
//   alu_a, alu_b, alu_cin    registered drive to the external ALU (0 outside LO/HI)
//   alu_sel                  registered select to the external ALU
//   alu_y, alu_cout          combinational ALU result and carry-out
//   rsp_valid/rsp_ready      response handshake
//   rsp_y, rsp_cout, rsp_err result, final carry, illegal-select flag
//   rsp_zero                 result-is-zero flag, present only with ALU_SEQ_ZERO_FLAG_EN
// Build option: ALU_SEQ_ZERO_FLAG_EN adds rsp_zero.
module alu_seq_ctrl #(
   parameter int DATA_W = alu_pkg::DATA_W,
   parameter int SEL_W  = alu_pkg::SEL_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [SEL_W-1:0]    req_sel,
   input  logic [2*DATA_W-1:0] req_a,
   input  logic [2*DATA_W-1:0] req_b,
   input  logic                req_cin,
   input  logic                req_wide,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   output logic                alu_cin,
   output logic [SEL_W-1:0]    alu_sel,
   input  logic [DATA_W-1:0]   alu_y,
   input  logic                alu_cout,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [2*DATA_W-1:0] rsp_y,
   output logic                rsp_cout,
`ifdef ALU_SEQ_ZERO_FLAG_EN
   output logic                rsp_zero,
`endif
   output logic                rsp_err
);

   import alu_pkg::*;

   state_t              state;
   logic [DATA_W-1:0]   a_hi;
   logic [DATA_W-1:0]   b_hi;
   logic                wide_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_y     <= '0;
         rsp_cout  <= 1'b0;
         rsp_err   <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
         rsp_zero  <= 1'b0;
`endif
         alu_a     <= '0;
         alu_b     <= '0;
         alu_cin   <= 1'b0;
         alu_sel   <= '0;
         a_hi      <= '0;
         b_hi      <= '0;
         wide_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  a_hi      <= req_a[2*DATA_W-1:DATA_W];
                  b_hi      <= req_b[2*DATA_W-1:DATA_W];
                  wide_q    <= req_wide;
                  rsp_y     <= '0;
                  rsp_cout  <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                  rsp_zero  <= 1'b0;
`endif
                  if (req_sel <= SEL_W'(ALU_SEL_MAX)) begin
                     state   <= LO;
                     rsp_err <= 1'b0;
                     alu_a   <= req_a[DATA_W-1:0];
                     alu_b   <= req_b[DATA_W-1:0];
                     alu_cin <= req_cin;
                     alu_sel <= req_sel;
                  end else begin
                     // Illegal select never reaches the ALU: respond directly.
                     state     <= RSP;
                     rsp_err   <= 1'b1;
                     rsp_valid <= 1'b1;
                  end
               end
            end

            LO: begin
               rsp_y[DATA_W-1:0] <= alu_y;
               if (wide_q) begin
                  // Second pass: high halves, low-pass carry chained through alu_cin.
                  state   <= HI;
                  alu_a   <= a_hi;
                  alu_b   <= b_hi;
                  alu_cin <= alu_cout;
               end else begin
                  state     <= RSP;
                  rsp_valid <= 1'b1;
                  rsp_cout  <= alu_cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                  rsp_zero  <= (alu_y == '0);
`endif
                  alu_a     <= '0;
                  alu_b     <= '0;
                  alu_cin   <= 1'b0;
                  alu_sel   <= '0;
               end
            end

            HI: begin
               rsp_y[2*DATA_W-1:DATA_W] <= alu_y;
               rsp_cout  <= alu_cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
               rsp_zero  <= (alu_y == '0) && (rsp_y[DATA_W-1:0] == '0);
`endif
               state     <= RSP;
               rsp_valid <= 1'b1;
               alu_a     <= '0;
               alu_b     <= '0;
               alu_cin   <= 1'b0;
               alu_sel   <= '0;
            end

            RSP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end

            default: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
